// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite register-bank slave.
// Response codes, channel FSM states and the word-index shift helper.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axil_resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HOLD,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  function automatic int idx_shift(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/axil_slave_regbank_if.sv
// AXI4-Lite bus bundle for the register-bank slave.
// The master drives requests, the slave drives readys and responses.
interface axil_slave_regbank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );

endinterface

// File: rtl/axil_reg_bank.sv
// Word register storage with one strobed write port and one comb read port.
// Byte strobes honoured only when AXIL_SLAVE_WSTRB_EN is defined.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                wr_ok,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata,
  output logic                rd_ok
);

  localparam int SH = idx_shift(DATA_W);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W-1:0] ridx;

  assign widx  = waddr >> SH;
  assign ridx  = raddr >> SH;
  assign wr_ok = widx < ADDR_W'(NUM_REGS);
  assign rd_ok = ridx < ADDR_W'(NUM_REGS);
  assign rdata = rd_ok ? regs[ridx[IW-1:0]] : '0;

`ifndef AXIL_SLAVE_WSTRB_EN
  logic unused_strb;
  assign unused_strb = ^wstrb;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && wr_ok) begin
`ifdef AXIL_SLAVE_WSTRB_EN
      for (int k = 0; k < DATA_W/8; k++) begin
        if (wstrb[k]) begin
          regs[widx[IW-1:0]][8*k +: 8] <= wdata[8*k +: 8];
        end
      end
`else
      regs[widx[IW-1:0]] <= wdata;
`endif
    end
  end

endmodule

// File: rtl/axil_slave_regbank.sv
// AXI4-Lite slave over a register bank; independent write and read FSMs.
// Optional byte-strobe writes: define AXIL_SLAVE_WSTRB_EN.
module axil_slave_regbank
  import axil_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int NUM_REGS = 8
) (
  input logic ACLK,
  input logic ARESETN,
  axil_slave_regbank_if.slave s_axi
);

  localparam int SW = DATA_W / 8;

  logic              rdy_en;
  wr_state_t         w_state;
  logic              aw_full;
  logic              w_full;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [SW-1:0]     w_strb_q;
  logic              bvalid_q;
  axil_resp_t        bresp_q;

  rd_state_t         r_state;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  axil_resp_t        rresp_q;

  logic              aw_rdy;
  logic              w_rdy;
  logic              ar_rdy;
  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              commit;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [SW-1:0]     wr_strb;
  logic              wr_ok;
  logic [DATA_W-1:0] bank_rdata;
  logic              rd_ok;

  // readys stay low until one edge after reset release
  assign aw_rdy = rdy_en && !aw_full && (w_state != W_RESP);
  assign w_rdy  = rdy_en && !w_full && (w_state != W_RESP);
  assign ar_rdy = rdy_en && !rvalid_q;

  assign aw_hs  = s_axi.AWVALID && aw_rdy;
  assign w_hs   = s_axi.WVALID && w_rdy;
  assign ar_hs  = s_axi.ARVALID && ar_rdy;
  assign commit = (aw_full || aw_hs) && (w_full || w_hs);

  assign wr_addr = aw_full ? aw_addr_q : s_axi.AWADDR;
  assign wr_data = w_full ? w_data_q : s_axi.WDATA;
  assign wr_strb = w_full ? w_strb_q : s_axi.WSTRB;

  assign s_axi.AWREADY = aw_rdy;
  assign s_axi.WREADY  = w_rdy;
  assign s_axi.ARREADY = ar_rdy;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RDATA   = rdata_q;
  assign s_axi.RRESP   = rresp_q;

  axil_reg_bank #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_bank (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .we    (commit),
    .waddr (wr_addr),
    .wdata (wr_data),
    .wstrb (wr_strb),
    .wr_ok (wr_ok),
    .raddr (s_axi.ARADDR),
    .rdata (bank_rdata),
    .rd_ok (rd_ok)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state   <= W_IDLE;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      unique case (w_state)
        W_IDLE, W_HOLD: begin
          if (commit) begin
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? OKAY : SLVERR;
            w_state  <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_full   <= 1'b1;
              aw_addr_q <= s_axi.AWADDR;
            end
            if (w_hs) begin
              w_full   <= 1'b1;
              w_data_q <= s_axi.WDATA;
              w_strb_q <= s_axi.WSTRB;
            end
            if (aw_hs || w_hs) begin
              w_state <= W_HOLD;
            end
          end
        end
        W_RESP: begin
          if (s_axi.BREADY) begin
            bvalid_q <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state  <= R_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= bank_rdata;
            rresp_q  <= rd_ok ? OKAY : SLVERR;
            r_state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi.RREADY) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_slave_regbank.sv
// Directed bench for axil_slave_regbank with a queue-based response scoreboard.
// Expected B/R responses are queued at issue and popped by a monitor.
module tb_axil_slave_regbank;

  logic ACLK;
  logic ARESETN;

  axil_slave_regbank_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  axil_slave_regbank #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .NUM_REGS (8)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .s_axi   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [1:0]  eb;
    logic [33:0] er;
    forever begin
      @(negedge ACLK);
      if (ARESETN && bus.BVALID && bus.BREADY) begin
        if (bq.size() == 0) begin
          chk("b_unexpected", 64'd1, 64'd0);
        end else begin
          eb = bq.pop_front();
          chk("bresp", 64'(bus.BRESP), 64'(eb));
        end
      end
      if (ARESETN && bus.RVALID && bus.RREADY) begin
        if (rq.size() == 0) begin
          chk("r_unexpected", 64'd1, 64'd0);
        end else begin
          er = rq.pop_front();
          chk("rdata", 64'(bus.RDATA), 64'(er[31:0]));
          chk("rresp", 64'(bus.RRESP), 64'(er[33:32]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] r);
    bit aw_ok = 0;
    bit w_ok = 0;
    int n = 0;
    bq.push_back(r);
    @(posedge ACLK); #1;
    bus.AWADDR = a; bus.AWVALID = 1'b1;
    bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
    while (!(aw_ok && w_ok) && n < 20) begin
      @(negedge ACLK);
      if (bus.AWVALID && bus.AWREADY) aw_ok = 1;
      if (bus.WVALID && bus.WREADY) w_ok = 1;
      @(posedge ACLK); #1;
      if (aw_ok) bus.AWVALID = 1'b0;
      if (w_ok) bus.WVALID = 1'b0;
      n++;
    end
    if (!(aw_ok && w_ok)) begin
      chk("aw_w_timeout", 64'd0, 64'd1);
      bus.AWVALID = 1'b0;
      bus.WVALID = 1'b0;
    end
    @(negedge ACLK);
    chk("b_latency", 64'(bus.BVALID), 64'd1);
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] r);
    bit ok = 0;
    int n = 0;
    rq.push_back({r, d});
    @(posedge ACLK); #1;
    bus.ARADDR = a; bus.ARVALID = 1'b1;
    while (!ok && n < 20) begin
      @(negedge ACLK);
      if (bus.ARREADY) ok = 1;
      @(posedge ACLK); #1;
      n++;
    end
    bus.ARVALID = 1'b0;
    if (!ok) chk("ar_timeout", 64'd0, 64'd1);
    @(negedge ACLK);
    chk("r_latency", 64'(bus.RVALID), 64'd1);
  endtask

  function automatic logic [40:0] outs();
    return {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID,
            bus.RVALID, bus.BRESP, bus.RRESP, bus.RDATA};
  endfunction

  initial begin
    logic [31:0] exp_s;
    logic [31:0] exp_z;
    ARESETN = 1'b0;
    bus.AWADDR = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b1;
    bus.ARADDR = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;

    // reset release
    repeat (5) @(negedge ACLK);
    chk("reset_outs", 64'(outs()), 64'd0);
    ARESETN = 1'b1;
    #1 chk("release_outs", 64'(outs()), 64'd0);
    @(negedge ACLK);
    chk("readys_up", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'h7);
    axi_read(32'h0, 32'h0, 2'b00);

    // basic write/read
    axi_write(32'h8, 32'hDEADBEEF, 4'hF, 2'b00);
    axi_read(32'h8, 32'hDEADBEEF, 2'b00);

    // out of range
    axi_write(32'h20, 32'h12345678, 4'hF, 2'b10);
    for (int i = 0; i < 8; i++) begin
      axi_read(32'(i * 4), (i == 2) ? 32'hDEADBEEF : 32'h0, 2'b00);
    end
    axi_read(32'h20, 32'h0, 2'b10);
    axi_read(32'h23, 32'h0, 2'b10);

    // decoupled order: W three cycles before AW
    bq.push_back(2'b00);
    @(posedge ACLK); #1;
    bus.WDATA = 32'hA5A5A5A5; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(negedge ACLK);
    chk("w_first_hs", 64'(bus.WREADY), 64'd1);
    @(posedge ACLK); #1;
    bus.WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("wready_held", 64'({bus.WREADY, bus.AWREADY, bus.BVALID}),
          64'b010);
      if (i < 2) begin
        @(posedge ACLK); #1;
      end
    end
    @(posedge ACLK); #1;
    bus.AWADDR = 32'h1C; bus.AWVALID = 1'b1;
    @(negedge ACLK);
    chk("aw_late_hs", 64'(bus.AWREADY), 64'd1);
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    @(negedge ACLK);
    chk("b_after_aw", 64'(bus.BVALID), 64'd1);
    axi_read(32'h1C, 32'hA5A5A5A5, 2'b00);

    // backpressure with same-edge write+read of reg 2 (old value read)
    bq.push_back(2'b00);
    rq.push_back({2'b00, 32'hDEADBEEF});
    @(posedge ACLK); #1;
    bus.BREADY = 1'b0; bus.RREADY = 1'b0;
    bus.AWADDR = 32'h8; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h0BADF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = 32'h8; bus.ARVALID = 1'b1;
    @(negedge ACLK);
    chk("all_hs", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'h7);
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("bp_hold", 64'(outs()), {23'd0, 5'b00011, 4'b0000, 32'hDEADBEEF});
    end
    @(posedge ACLK); #1;
    bus.BREADY = 1'b1; bus.RREADY = 1'b1;
    axi_read(32'h8, 32'h0BADF00D, 2'b00);

    // strobes
`ifdef AXIL_SLAVE_WSTRB_EN
    exp_s = 32'hFF00FF00;
    exp_z = 32'hFF00FF00;
`else
    exp_s = 32'h00000000;
    exp_z = 32'h12345678;
`endif
    axi_write(32'h4, 32'hFFFFFFFF, 4'hF, 2'b00);
    axi_write(32'h4, 32'h00000000, 4'b0101, 2'b00);
    axi_read(32'h4, exp_s, 2'b00);
    axi_write(32'h4, 32'h12345678, 4'b0000, 2'b00);
    axi_read(32'h4, exp_z, 2'b00);

    // reset mid-transaction: AW captured, then async reset
    @(posedge ACLK); #1;
    bus.AWADDR = 32'hC; bus.AWVALID = 1'b1;
    @(negedge ACLK);
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    #2 ARESETN = 1'b0;
    #1 chk("async_rst_outs", 64'(outs()), 64'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("readys_up2", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'h7);
    axi_read(32'h8, 32'h0, 2'b00);
    axi_write(32'h10, 32'h00C0FFEE, 4'hF, 2'b00);
    axi_read(32'hC, 32'h0, 2'b00);
    axi_read(32'h10, 32'h00C0FFEE, 2'b00);

    repeat (3) @(negedge ACLK);
    chk("b_queue_empty", 64'(bq.size()), 64'd0);
    chk("r_queue_empty", 64'(rq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
